// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction/PC buffer between fetch and decode, with flush and halt blocking
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 8,
    parameter int PC_W    = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [INSTR_W-1:0]         i_in_instr,
    input  logic [PC_W-1:0]            i_in_pc,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [INSTR_W-1:0]         o_out_instr,
    output logic [PC_W-1:0]            o_out_pc,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_halt_drained
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [PC_W-1:0]    r_pc_mem    [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_cnt;
    logic               r_halt_seen;
    logic               w_push;
    logic               w_pop;
    logic               w_clear;
    logic               w_is_halt;

    assign w_clear        = !i_rst_n || i_flush;
    assign o_in_ready     = (r_cnt < CW'(DEPTH)) && !r_halt_seen;
    assign o_out_valid    = r_cnt != '0;
    assign w_push         = i_in_valid && o_in_ready;
    assign w_pop          = o_out_valid && i_out_ready;
    assign w_is_halt      = i_in_instr[INSTR_W-1 -: 2] == 2'b11;
    assign o_out_instr    = o_out_valid ? r_instr_mem[r_rd_ptr] : '0;
    assign o_out_pc       = o_out_valid ? r_pc_mem[r_rd_ptr] : '0;
    assign o_count        = r_cnt;
    assign o_halt_drained = r_halt_seen && (r_cnt == '0);

    // Store accepted entries; a push coinciding with reset or flush is dropped
    always_ff @(posedge i_clk) begin
        if (w_push && !w_clear) begin
            r_instr_mem[r_wr_ptr] <= i_in_instr;
            r_pc_mem[r_wr_ptr]    <= i_in_pc;
        end
    end

    // Pointers, occupancy and halt block; reset and flush both empty the queue
    always_ff @(posedge i_clk) begin
        if (w_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_halt_seen <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (w_push && w_is_halt) r_halt_seen <= 1'b1;
        end
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Decoupling instruction queue between the fetch stage and the decode stage of the 8-bit CPU.
- Accepts {instr, pc} pairs from fetch over a valid/ready handshake.
- Buffers them in a small circular FIFO and presents them in order to decode over a second valid/ready handshake.
- Supports pipeline flush on redirect.
- Blocks further fetch once a halt opcode (instr[7:6] == 2'b11) has been enqueued.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- INSTR_W, 8, instruction width in bits.
- PC_W, 8, program-counter width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  fetch presents a valid instruction.
- in_ready  output  1  queue can accept a push this cycle.
- in_instr  input  INSTR_W  instruction from fetch.
- in_pc  input  PC_W  PC of in_instr.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes head this cycle.
- out_instr  output  INSTR_W  head instruction.
- out_pc  output  PC_W  head PC.
- flush  input  1  discard all entries and clear halt block.
- count  output  $clog2(DEPTH)+1  current occupancy.
- halt_drained  output  1  halt enqueued and queue now empty.

Behaviour:
- State:
  - Storage arrays instr_mem[DEPTH] and pc_mem[DEPTH].
  - Write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping naturally modulo DEPTH.
  - Occupancy register cnt.
  - Flag halt_seen.
- Reset (rst_n == 0 at a clock edge): wr_ptr = 0, rd_ptr = 0, cnt = 0, halt_seen = 0. Storage contents are don't-care.
- Outputs immediately after reset: in_ready = 1, out_valid = 0, out_instr = 0, out_pc = 0, count = 0, halt_drained = 0.
- Reset mid-operation discards all entries identically to a flush.
- in_ready = (cnt < DEPTH) && !halt_seen. It is combinational from state only and never depends on out_ready, so there is no full-queue pass-through.
- push = in_valid && in_ready. pop = out_valid && out_ready.
- out_valid = (cnt != 0).
  - When out_valid = 1, out_instr/out_pc = instr_mem[rd_ptr]/pc_mem[rd_ptr].
  - When out_valid = 0, out_instr and out_pc are driven to 0.
- Latency: a push into an empty queue appears at out_valid on the following cycle. There is no same-cycle bypass.
- On push: write the entry at wr_ptr, then wr_ptr += 1.
- On pop: rd_ptr += 1.
- cnt update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, which is legal whenever 0 < cnt < DEPTH.
- Empty queue: pop cannot occur because out_valid = 0. A push alone moves cnt to 1.
- Full queue (cnt == DEPTH): in_ready = 0, so no push. A pop that cycle frees one slot, and in_ready rises on the next cycle.
- Halt handling:
  - If push occurs with in_instr[7:6] == 2'b11, halt_seen is set on the next edge.
  - The halt instruction itself is stored and delivered to decode normally.
  - Entries already queued ahead of the halt are delivered in order.
  - While halt_seen = 1, in_ready = 0.
- halt_drained = halt_seen && (cnt == 0), registered-state derived and combinational.
- Flush (flush == 1 at a clock edge) has the highest priority after reset:
  - wr_ptr = 0, rd_ptr = 0, cnt = 0, halt_seen = 0.
  - Any push or pop in that cycle is discarded. The pushed data is not stored, and a pop has no effect beyond the clear.
  - Outputs return to reset values on the following cycle.
- Invariant: 0 <= cnt <= DEPTH.
- Invariant: (wr_ptr - rd_ptr) mod DEPTH == cnt mod DEPTH.

Test Plan:
1. Reset with rst_n = 0 for 2 cycles, then release -> in_ready = 1, out_valid = 0, count = 0, out_instr = 8'h00, out_pc = 8'h00, halt_drained = 0.
2. Fill with out_ready = 0: push {8'h11,8'h00}, {8'h22,8'h01}, {8'h33,8'h02}, {8'h44,8'h03} -> count = 4 and in_ready = 0. A fifth in_valid with 8'h55 is not accepted. Then raise out_ready -> outputs 8'h11, 8'h22, 8'h33, 8'h44 with PCs 0..3 on successive cycles, after which count = 0.
3. Streaming with in_valid = out_ready = 1 for 10 cycles, instr = 8'h01..8'h0A -> count holds at 1 after the first cycle, pointers wrap past DEPTH, and out_instr sequence is 8'h01..8'h0A with no loss or duplication.
4. Flush with 3 entries queued while in_valid = 1 (8'h66) in the same cycle -> the next cycle has count = 0, out_valid = 0, and in_ready = 1. 8'h66 is never delivered.
5. Halt: push 8'h12, 8'hC0, then offer 8'h34 -> 8'h34 is refused (in_ready = 0 the cycle after 8'hC0 is accepted). Decode receives 8'h12 then 8'hC0. halt_drained = 1 once count = 0, and it stays 1 until flush, after which in_ready = 1 and halt_drained = 0.
6. Synchronous reset asserted with 2 entries queued and push/pop active -> state is cleared at that edge, identically to scenario 1.
